// File: rtl/square_channel_sequencer.sv
// Control unit for one square-wave voice: channel registers, 512 Hz frame sequencer,
// length counter, volume envelope and frequency sweep driving the tone generator.
module square_channel_sequencer #(
    parameter int FRAME_DIV = 8192
) (
    input  logic        I_BITCLK,
    input  logic        I_RESET,
    input  logic        I_WR_EN,
    input  logic [2:0]  I_WR_ADDR,
    input  logic [7:0]  I_WR_DATA,
    output logic [10:0] O_FREQUENCY,
    output logic [1:0]  O_DUTY_CYCLE,
    output logic [3:0]  O_VOLUME,
    output logic        O_WAVEFORM_EN,
    output logic [2:0]  O_FRAME_STEP
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CALC    = 2'd1;
    localparam logic [1:0] S_APPLY   = 2'd2;
    localparam logic [1:0] S_RECHECK = 2'd3;

    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       nr10;
    logic [7:0]       nr12;
    logic [7:0]       nr13;
    logic             len_en;
    logic [2:0]       freq_hi;

    logic [6:0]       len_cnt;
    logic [2:0]       env_tmr;
    logic [10:0]      shadow;
    logic [3:0]       sw_tmr;
    logic             sw_en;
    logic [1:0]       sw_state;
    logic             check_only;
    logic [11:0]      nf_p1;

    logic wr_nr10, wr_nr11, wr_nr12, wr_nr13, wr_nr14, trigger;
    logic tick, tick_eff, len_tick, sw_tick, env_tick, dac_on;
    logic [2:0]  sw_period;
    logic        sw_neg;
    logic [2:0]  sw_shift;
    logic [11:0] recheck_nf;

    // Shadow +/- (shadow >> shift), one bit wider so overflow past 2047 is visible.
    function automatic logic [11:0] sweep_calc(input logic [10:0] f, input logic neg,
                                               input logic [2:0] sh);
        logic [11:0] base;
        logic [11:0] delta;
        base  = {1'b0, f};
        delta = base >> sh;
        return neg ? (base - delta) : (base + delta);
    endfunction

    function automatic logic [3:0] env_step(input logic [3:0] v, input logic up);
        if (up)
            return (v == 4'hF) ? v : v + 4'd1;
        else
            return (v == 4'h0) ? v : v - 4'd1;
    endfunction

    function automatic logic [3:0] sw_reload(input logic [2:0] p);
        return (p == 3'd0) ? 4'd8 : {1'b0, p};
    endfunction

    always_comb begin
        wr_nr10    = I_WR_EN && (I_WR_ADDR == 3'd0);
        wr_nr11    = I_WR_EN && (I_WR_ADDR == 3'd1);
        wr_nr12    = I_WR_EN && (I_WR_ADDR == 3'd2);
        wr_nr13    = I_WR_EN && (I_WR_ADDR == 3'd3);
        wr_nr14    = I_WR_EN && (I_WR_ADDR == 3'd4);
        trigger    = wr_nr14 && I_WR_DATA[7];
        tick       = (div_cnt == DIV_LAST);
        // A trigger swallows any tick landing in the same cycle.
        tick_eff   = tick && !trigger;
        len_tick   = tick_eff && !O_FRAME_STEP[0];
        sw_tick    = tick_eff && (O_FRAME_STEP[1:0] == 2'b10);
        env_tick   = tick_eff && (O_FRAME_STEP == 3'd7);
        dac_on     = |nr12[7:3];
        sw_period  = nr10[6:4];
        sw_neg     = nr10[3];
        sw_shift   = nr10[2:0];
        recheck_nf = sweep_calc(shadow, sw_neg, sw_shift);
    end

    always_ff @(posedge I_BITCLK or posedge I_RESET) begin
        if (I_RESET) begin
            div_cnt      <= '0;
            O_FRAME_STEP <= 3'd0;
        end else if (tick) begin
            div_cnt      <= '0;
            O_FRAME_STEP <= O_FRAME_STEP + 3'd1;
        end else begin
            div_cnt      <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge I_BITCLK or posedge I_RESET) begin
        if (I_RESET) begin
            nr10         <= '0;
            nr12         <= '0;
            nr13         <= '0;
            len_en       <= 1'b0;
            freq_hi      <= '0;
            O_DUTY_CYCLE <= '0;
        end else begin
            if (wr_nr10) nr10 <= I_WR_DATA[6:0];
            if (wr_nr11) O_DUTY_CYCLE <= I_WR_DATA[7:6];
            if (wr_nr12) nr12 <= I_WR_DATA;
            if (wr_nr13) nr13 <= I_WR_DATA;
            if (wr_nr14) begin
                len_en  <= I_WR_DATA[6];
                freq_hi <= I_WR_DATA[2:0];
            end
        end
    end

    always_ff @(posedge I_BITCLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_WAVEFORM_EN <= 1'b0;
            O_VOLUME      <= '0;
            O_FREQUENCY   <= '0;
            len_cnt       <= '0;
            env_tmr       <= '0;
            shadow        <= '0;
            sw_tmr        <= '0;
            sw_en         <= 1'b0;
            sw_state      <= S_IDLE;
            check_only    <= 1'b0;
            nf_p1         <= '0;
        end else begin
            if (wr_nr11)
                len_cnt <= 7'd64 - {1'b0, I_WR_DATA[5:0]};
            else if (len_tick && len_en && (len_cnt != 7'd0)) begin
                len_cnt <= len_cnt - 7'd1;
                if (len_cnt == 7'd1) O_WAVEFORM_EN <= 1'b0;
            end

            if (env_tick && (nr12[2:0] != 3'd0)) begin
                if (env_tmr <= 3'd1) begin
                    env_tmr  <= nr12[2:0];
                    O_VOLUME <= env_step(O_VOLUME, nr12[3]);
                end else begin
                    env_tmr  <= env_tmr - 3'd1;
                end
            end

            if (wr_nr13) O_FREQUENCY <= {freq_hi, I_WR_DATA};
            if (wr_nr14) O_FREQUENCY <= {I_WR_DATA[2:0], nr13};
            if (wr_nr12 && (I_WR_DATA[7:3] == 5'd0)) O_WAVEFORM_EN <= 1'b0;

            case (sw_state)
                S_IDLE: begin
                    if (sw_tick) begin
                        if (sw_tmr <= 4'd1) begin
                            sw_tmr <= sw_reload(sw_period);
                            if (sw_en && (sw_period != 3'd0)) begin
                                sw_state   <= S_CALC;
                                check_only <= 1'b0;
                            end
                        end else begin
                            sw_tmr <= sw_tmr - 4'd1;
                        end
                    end
                end
                // Stage p1: register the candidate frequency.
                S_CALC: begin
                    nf_p1    <= sweep_calc(shadow, sw_neg, sw_shift);
                    sw_state <= S_APPLY;
                end
                // Overflow test on p1; commit only for a full (non-trigger) sweep.
                S_APPLY: begin
                    if (nf_p1 > 12'd2047) begin
                        O_WAVEFORM_EN <= 1'b0;
                        sw_state      <= S_IDLE;
                    end else if (check_only) begin
                        sw_state <= S_IDLE;
                    end else begin
                        if (sw_shift != 3'd0) begin
                            shadow      <= nf_p1[10:0];
                            O_FREQUENCY <= nf_p1[10:0];
                        end
                        sw_state <= S_RECHECK;
                    end
                end
                default: begin
                    if (recheck_nf > 12'd2047) O_WAVEFORM_EN <= 1'b0;
                    sw_state <= S_IDLE;
                end
            endcase

            // Trigger is last so it overrides any in-flight sweep or tick effect.
            if (trigger) begin
                O_WAVEFORM_EN <= dac_on;
                if (len_cnt == 7'd0) len_cnt <= 7'd64;
                O_VOLUME <= nr12[7:4];
                env_tmr  <= nr12[2:0];
                shadow   <= {I_WR_DATA[2:0], nr13};
                sw_tmr   <= sw_reload(sw_period);
                sw_en    <= (sw_period != 3'd0) || (sw_shift != 3'd0);
                if (sw_shift != 3'd0) begin
                    sw_state   <= S_CALC;
                    check_only <= 1'b1;
                end else begin
                    sw_state   <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_square_channel_sequencer.sv
// Scoreboard bench for square_channel_sequencer with a short frame divider.
module tb_square_channel_sequencer;

    localparam int FD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [10:0] O_FREQUENCY;
    logic [1:0]  O_DUTY_CYCLE;
    logic [3:0]  O_VOLUME;
    logic        O_WAVEFORM_EN;
    logic [2:0]  O_FRAME_STEP;

    square_channel_sequencer #(.FRAME_DIV(FD)) dut (
        .I_BITCLK     (clk),
        .I_RESET      (rst),
        .I_WR_EN      (wr_en),
        .I_WR_ADDR    (wr_addr),
        .I_WR_DATA    (wr_data),
        .O_FREQUENCY  (O_FREQUENCY),
        .O_DUTY_CYCLE (O_DUTY_CYCLE),
        .O_VOLUME     (O_VOLUME),
        .O_WAVEFORM_EN(O_WAVEFORM_EN),
        .O_FRAME_STEP (O_FRAME_STEP)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_act;
    int   n_checks = 0;
    int   n_pass = 0;
    int   timeouts = 0;

    // Independent frame-sequencer position model.
    int ref_div;
    int ref_step;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_div  <= 0;
            ref_step <= 0;
        end else if (ref_div == FD - 1) begin
            ref_div  <= 0;
            ref_step <= (ref_step + 1) % 8;
        end else begin
            ref_div  <= ref_div + 1;
        end
    end

    function automatic int pick(input int sel);
        case (sel)
            0:       return int'(O_FREQUENCY);
            1:       return int'(O_DUTY_CYCLE);
            2:       return int'(O_VOLUME);
            3:       return int'(O_WAVEFORM_EN);
            4:       return int'(O_FRAME_STEP);
            default: return timeouts;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = pick(mon_e.sel);
            n_checks++;
            if (mon_act == mon_e.val)
                n_pass++;
            else
                $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_e.name, mon_act, mon_e.val);
        end
    end

    task automatic expect_out(input string nm, input int sel, input int val);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step_clk(1);
        wr_en   = 1'b0;
    endtask

    // Return just after the next tick whose step is selected in the mask.
    task automatic wait_tick(input logic [7:0] steps);
        for (int k = 0; k < 400; k++) begin
            if (ref_div == FD - 1 && steps[ref_step]) begin
                step_clk(1);
                return;
            end
            step_clk(1);
        end
        timeouts++;
        expect_out("tick_timeout", 5, 0);
    endtask

    // Return at the start of the cycle in which the selected tick fires.
    task automatic wait_tick_cycle(input logic [7:0] steps);
        for (int k = 0; k < 400; k++) begin
            if (ref_div == FD - 1 && steps[ref_step]) return;
            step_clk(1);
        end
        timeouts++;
        expect_out("tick_cycle_timeout", 5, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step_clk(2);
        expect_out("reset_freq", 0, 0);
        expect_out("reset_duty", 1, 0);
        expect_out("reset_vol", 2, 0);
        expect_out("reset_en", 3, 0);
        expect_out("reset_step", 4, 0);
        step_clk(1);
        rst = 1'b0;

        // Length counter: L=62 gives two length ticks of life.
        wait_tick(8'hFF);
        expect_out("step_track", 4, ref_step);
        wr(3'd2, 8'hF0);
        wr(3'd1, 8'h3E);
        wr(3'd4, 8'hC0);
        expect_out("len_trig_en", 3, 1);
        expect_out("len_trig_vol", 2, 15);
        expect_out("len_duty0", 1, 0);
        wait_tick(8'h55);
        expect_out("len_tick1_en", 3, 1);
        wait_tick(8'h55);
        expect_out("len_tick2_en", 3, 0);
        wr(3'd1, 8'hBE);
        expect_out("duty2", 1, 2);

        // Envelope: volume 2, down, period 1.
        wait_tick(8'hFF);
        wr(3'd2, 8'h21);
        wr(3'd4, 8'h80);
        expect_out("env_trig_vol", 2, 2);
        expect_out("env_trig_en", 3, 1);
        wait_tick(8'h80);
        expect_out("env_vol1", 2, 1);
        wait_tick(8'h80);
        expect_out("env_vol0", 2, 0);
        wait_tick(8'h80);
        expect_out("env_vol_sat", 2, 0);

        // Sweep up: period 1, shift 1, from 0x100.
        wait_tick(8'hFF);
        wr(3'd0, 8'h11);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h81);
        expect_out("sweep_trig_freq", 0, 'h100);
        expect_out("sweep_trig_en", 3, 1);
        wait_tick(8'h44);
        step_clk(3);
        expect_out("sweep1_freq", 0, 'h180);
        expect_out("sweep1_en", 3, 1);
        wait_tick(8'h44);
        step_clk(3);
        expect_out("sweep2_freq", 0, 'h240);

        // Overflow found by the trigger-time check.
        wait_tick(8'hFF);
        wr(3'd3, 8'hF0);
        wr(3'd4, 8'h87);
        expect_out("ovf_trig_freq", 0, 'h7F0);
        expect_out("ovf_trig_en", 3, 1);
        step_clk(2);
        expect_out("ovf_en_off", 3, 0);

        // DAC off drops the channel.
        wr(3'd2, 8'hF0);
        wr(3'd0, 8'h00);
        wr(3'd4, 8'h80);
        expect_out("dac_trig_en", 3, 1);
        wr(3'd2, 8'h07);
        expect_out("dac_off_en", 3, 0);

        // Trigger colliding with a step-7 tick: tick is dropped, timer reloaded to 2.
        wait_tick(8'hFF);
        wr(3'd2, 8'h52);
        wait_tick_cycle(8'h80);
        wr(3'd4, 8'h80);
        expect_out("coll_vol", 2, 5);
        expect_out("coll_en", 3, 1);
        wait_tick(8'h80);
        expect_out("coll_vol_hold", 2, 5);
        wait_tick(8'h80);
        expect_out("coll_vol_dec", 2, 4);

        // Reset in the middle of a sweep.
        wait_tick(8'hFF);
        wr(3'd2, 8'hF0);
        wr(3'd0, 8'h11);
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h81);
        wait_tick(8'h44);
        step_clk(1);
        rst = 1'b1;
        expect_out("midrst_freq", 0, 0);
        expect_out("midrst_duty", 1, 0);
        expect_out("midrst_vol", 2, 0);
        expect_out("midrst_en", 3, 0);
        expect_out("midrst_step", 4, 0);
        step_clk(2);
        rst = 1'b0;
        step_clk(4);
        expect_out("postrst_freq", 0, 0);
        expect_out("postrst_step", 4, 0);

        step_clk(3);
        if (n_checks == 0)
            $display("FAIL no checks executed");
        if (timeouts != 0)
            $display("FAIL %0d tick waits timed out", timeouts);
        if (n_pass != n_checks)
            $display("FAIL %0d of %0d checks failed", n_checks - n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
